// File: rtl/key_press_conditioner_if.sv
// Key-side signal bundle: one raw active-low button in, conditioned events out.
// The bench or pin wrapper drives key_n through master; the conditioner uses slave.
interface key_press_conditioner_if;
  logic       key_n;
  logic       press_pulse;
  logic       release_pulse;
  logic       held;
  logic [7:0] press_count;

  modport master (
    output key_n,
    input  press_pulse,
    input  release_pulse,
    input  held,
    input  press_count
  );

  modport slave (
    input  key_n,
    output press_pulse,
    output release_pulse,
    output held,
    output press_count
  );
endinterface

// File: rtl/key_press_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce FSM, press/release strobes,
// held level, optional auto-repeat and a wrapping press counter.
module key_press_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input logic                    clk,
  input logic                    reset,
  key_press_conditioner_if.slave kp
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [19:0] CNT_LAST    = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [24:0] RCNT_LAST   = 25'(REPEAT_DELAY - 1);
  localparam logic [24:0] RCNT_RELOAD = 25'(REPEAT_DELAY - REPEAT_PERIOD);

  state_t      state_q;
  logic        sync1_q;
  logic        sync2_q;
  logic [19:0] cnt_q;
  logic [24:0] rcnt_q;
  logic        press_q;
  logic        release_q;
  logic        held_q;
  logic [7:0]  count_q;
  logic        pressed_s;

  assign pressed_s = ~sync2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      sync1_q   <= kp.key_n;
      sync2_q   <= sync1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pressed_s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= 20'd1;
          end
        end
        PRESS_WAIT: begin
          if (!pressed_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HELD;
            cnt_q   <= '0;
            press_q <= 1'b1;
            held_q  <= 1'b1;
            count_q <= count_q + 8'd1;
            rcnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        HELD: begin
          if (!pressed_s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= 20'd1;
          end else if (REPEAT_EN) begin
            // Reload so the next pulse lands REPEAT_PERIOD after this one.
            if (rcnt_q == RCNT_LAST) begin
              press_q <= 1'b1;
              rcnt_q  <= RCNT_RELOAD;
            end else begin
              rcnt_q <= rcnt_q + 25'd1;
            end
          end
        end
        RELEASE_WAIT: begin
          // A release bounce returns to HELD with the repeat schedule untouched.
          if (pressed_s) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            release_q <= 1'b1;
            held_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kp.press_pulse   = press_q;
  assign kp.release_pulse = release_q;
  assign kp.held          = held_q;
  assign kp.press_count   = count_q;

endmodule

// File: tb/tb_key_press_conditioner.sv
// Bench for key_press_conditioner: two instances (repeat off/on) share one key and are
// compared every cycle against a run-length debounce model, plus directed timing checks.
module tb_key_press_conditioner;
  localparam int D      = 4;
  localparam int DELAY  = 10;
  localparam int PERIOD = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic key_n_drv = 1'b1;
  always #5 clk = ~clk;

  key_press_conditioner_if if0 ();
  key_press_conditioner_if if1 ();
  assign if0.key_n = key_n_drv;
  assign if1.key_n = key_n_drv;

  key_press_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b0), .REPEAT_DELAY(DELAY),
                          .REPEAT_PERIOD(PERIOD))
    dut0 (.clk(clk), .reset(reset), .kp(if0));
  key_press_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b1), .REPEAT_DELAY(DELAY),
                          .REPEAT_PERIOD(PERIOD))
    dut1 (.clk(clk), .reset(reset), .kp(if1));

  wire [10:0] obs0 = {if0.press_pulse, if0.release_pulse, if0.held, if0.press_count};
  wire [10:0] obs1 = {if1.press_pulse, if1.release_pulse, if1.held, if1.press_count};

  int checks = 0;
  int failures = 0;

  // Model: a level is accepted after D consecutive synchronized samples that differ
  // from the current debounced level; repeats fire on held-ticks DELAY, DELAY+PERIOD, ...
  bit       m_s1 = 1'b1, m_s2 = 1'b1;
  bit       m_lvl = 1'b0;
  int       m_run = 0;
  int       m_ticks = 0;
  bit [7:0] m_cnt = 8'd0;
  bit       m_acc = 1'b0, m_rel = 1'b0, m_rep = 1'b0;

  function automatic logic [10:0] exp_vec(input bit rep_en);
    return {m_acc | (rep_en & m_rep), m_rel, m_lvl, m_cnt};
  endfunction

  task automatic step(input logic k, input logic rs);
    bit ps;
    key_n_drv = k;
    reset = rs;
    @(posedge clk);
    m_acc = 1'b0; m_rel = 1'b0; m_rep = 1'b0;
    if (!rs) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0; m_run = 0; m_ticks = 0; m_cnt = 8'd0;
    end else begin
      ps = !m_s2;
      if (ps == m_lvl) begin
        if (m_lvl && m_run == 0) begin
          m_ticks++;
          m_rep = (m_ticks >= DELAY) && ((m_ticks - DELAY) % PERIOD == 0);
        end
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == D) begin
          m_lvl = ps;
          m_run = 0;
          if (ps) begin m_acc = 1'b1; m_cnt = m_cnt + 8'd1; m_ticks = 0; end
          else m_rel = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = k;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1);
      checks += 2;
      if (obs0 !== 11'd0) begin failures++; $display("FAIL reset dut0 cyc %0d: got %b want 0", i, obs0); end
      if (obs1 !== 11'd0) begin failures++; $display("FAIL reset dut1 cyc %0d: got %b want 0", i, obs1); end
    end
  endtask

  task automatic test_single_press();
    int press_at = -1, extra = 0, rel_at = -1, held_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (obs0 !== exp_vec(0)) begin failures++; $display("FAIL press_model cyc %0d: got %b want %b", i, obs0, exp_vec(0)); end
      if (if0.press_pulse) begin if (press_at < 0) press_at = i; else extra++; end
      if (if0.held && held_at < 0) held_at = i;
    end
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (obs0 !== exp_vec(0)) begin failures++; $display("FAIL release_model cyc %0d: got %b want %b", i, obs0, exp_vec(0)); end
      if (if0.release_pulse) begin
        rel_at = i;
        checks++;
        if (if0.held !== 1'b0) begin failures++; $display("FAIL release_held got %b want 0", if0.held); end
      end
    end
    checks += 5;
    if (press_at != D + 2) begin failures++; $display("FAIL press_latency got %0d want %0d", press_at, D + 2); end
    if (extra != 0) begin failures++; $display("FAIL press_extra got %0d want 0", extra); end
    if (held_at != D + 2) begin failures++; $display("FAIL held_rise got %0d want %0d", held_at, D + 2); end
    if (rel_at != D + 2) begin failures++; $display("FAIL release_latency got %0d want %0d", rel_at, D + 2); end
    if (if0.press_count !== 8'd1) begin failures++; $display("FAIL press_count got %0d want 1", if0.press_count); end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    logic pat [$] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1};
    step(1'b1, 1'b0);
    foreach (pat[i]) begin
      step(pat[i], 1'b1);
      checks++;
      if (obs0 !== exp_vec(0)) begin failures++; $display("FAIL bounce_model cyc %0d: got %b want %b", i, obs0, exp_vec(0)); end
      if (if0.press_pulse || if0.held) pulses++;
    end
    checks += 2;
    if (pulses != 0) begin failures++; $display("FAIL bounce_activity got %0d want 0", pulses); end
    if (if0.press_count !== 8'd0) begin failures++; $display("FAIL bounce_count got %0d want 0", if0.press_count); end
  endtask

  task automatic test_release_glitch();
    int rel = 0, presses = 0, not_held = 0;
    step(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step((i < 2) ? 1'b1 : 1'b0, 1'b1);
      checks++;
      if (obs0 !== exp_vec(0)) begin failures++; $display("FAIL glitch_model cyc %0d: got %b want %b", i, obs0, exp_vec(0)); end
      if (if0.release_pulse) rel++;
      if (if0.press_pulse) presses++;
      if (!if0.held) not_held++;
    end
    checks += 4;
    if (rel != 0) begin failures++; $display("FAIL glitch_release got %0d want 0", rel); end
    if (presses != 0) begin failures++; $display("FAIL glitch_press got %0d want 0", presses); end
    if (not_held != 0) begin failures++; $display("FAIL glitch_held_drop got %0d want 0", not_held); end
    if (if0.press_count !== 8'd1) begin failures++; $display("FAIL glitch_count got %0d want 1", if0.press_count); end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
  endtask

  task automatic test_repeat();
    int offs [$];
    int want [$] = '{10, 13, 16, 19, 22, 25, 28};
    int acc_at = -1, rep0 = 0;
    step(1'b1, 1'b0);
    for (int i = 1; i <= D + 2 + 30; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (obs1 !== exp_vec(1)) begin failures++; $display("FAIL repeat_model cyc %0d: got %b want %b", i, obs1, exp_vec(1)); end
      if (if1.press_pulse) begin if (acc_at < 0) acc_at = i; else offs.push_back(i - acc_at); end
      if (if0.press_pulse && acc_at >= 0 && i != acc_at) rep0++;
    end
    checks += 3;
    if (offs.size() != want.size()) begin failures++; $display("FAIL repeat_num got %0d want %0d", offs.size(), want.size()); end
    else foreach (want[k]) begin
      checks++;
      if (offs[k] != want[k]) begin failures++; $display("FAIL repeat_off[%0d] got %0d want %0d", k, offs[k], want[k]); end
    end
    if (rep0 != 0) begin failures++; $display("FAIL repeat_off_dut got %0d want 0", rep0); end
    if (if1.press_count !== 8'd1) begin failures++; $display("FAIL repeat_count got %0d want 1", if1.press_count); end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0);
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 14; i++) begin
        step((i < 7) ? 1'b0 : 1'b1, 1'b1);
        checks += 2;
        if (obs0 !== exp_vec(0)) begin failures++; $display("FAIL wrap_model0 p %0d cyc %0d: got %b want %b", p, i, obs0, exp_vec(0)); end
        if (obs1 !== exp_vec(1)) begin failures++; $display("FAIL wrap_model1 p %0d cyc %0d: got %b want %b", p, i, obs1, exp_vec(1)); end
      end
    end
    checks += 2;
    if (if0.press_count !== 8'd0) begin failures++; $display("FAIL wrap_count0 got %0d want 0", if0.press_count); end
    if (if1.press_count !== 8'd0) begin failures++; $display("FAIL wrap_count1 got %0d want 0", if1.press_count); end
  endtask

  task automatic test_reset_while_held();
    int press_at = -1;
    step(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
    checks++;
    if (if0.held !== 1'b1) begin failures++; $display("FAIL rwh_pre_held got %b want 1", if0.held); end
    step(1'b0, 1'b0);
    checks++;
    if (obs0 !== 11'd0) begin failures++; $display("FAIL rwh_reset got %b want 0", obs0); end
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (if0.release_pulse !== 1'b0) begin failures++; $display("FAIL rwh_release cyc %0d got 1 want 0", i); end
      if (if0.press_pulse && press_at < 0) press_at = i;
    end
    checks++;
    if (press_at != D + 2) begin failures++; $display("FAIL rwh_press_latency got %0d want %0d", press_at, D + 2); end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic lvl = 1'b1;
    logic rs;
    step(1'b1, 1'b0);
    for (int s = 0; s < 80; s++) begin
      int len = $urandom_range(1, 20);
      lvl = ~lvl;
      for (int i = 0; i < len; i++) begin
        rs = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
        step(lvl, rs);
        checks += 2;
        if (obs0 !== exp_vec(0)) begin failures++; $display("FAIL random_model0 seg %0d cyc %0d: got %b want %b", s, i, obs0, exp_vec(0)); end
        if (obs1 !== exp_vec(1)) begin failures++; $display("FAIL random_model1 seg %0d cyc %0d: got %b want %b", s, i, obs1, exp_vec(1)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_release_glitch();
    test_repeat();
    test_wrap();
    test_reset_while_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/key_press_conditioner.md
Name: key_press_conditioner

Overview:
- Receive side of the pushbutton stimulus the board and bench apply to KEY[3:0].
- Takes one raw active-low KEY line, clocked at 50 MHz. Synchronizes it, debounces it, and turns it into clean events for game logic: a one-cycle flap pulse, a release pulse, a held level, optional auto-repeat, and a press counter.
- One instance per KEY bit, placed between the top-level pins and the game FSM.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range 2..2^20-1.
- REPEAT_EN, 0, 1 enables auto-repeat pulses while held; 0 disables them.
- REPEAT_DELAY, 25000000, held cycles after the accepted press before the first repeat pulse.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses.

Ports:
- clk  input  1  system clock, CLOCK_50 domain.
- reset  input  1  synchronous, active-low; sampled on the rising clk edge.
- key_n  input  1  raw asynchronous button, 0 = pressed.
- press_pulse  output  1  one-cycle strobe on an accepted press or repeat.
- release_pulse  output  1  one-cycle strobe on an accepted release.
- held  output  1  high while the debounced button is pressed.
- press_count  output  8  number of accepted presses, excluding repeats; wraps 255->0.

Behaviour:
- Synchronizer:
  - Two flops on key_n, reset to 1 (released).
  - pressed_s = ~sync2.
- Reset (reset==0 at a clk edge):
  - state=IDLE; all counters 0.
  - press_pulse=0, release_pulse=0, held=0, press_count=0.
  - Reset overrides everything, including mid-debounce or mid-hold. No pulse is emitted on reset entry or exit.
  - If the key is still low after reset deasserts, it is treated as a fresh press and must fully debounce.
- All outputs are registered. press_pulse and release_pulse are never high in the same cycle.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. cnt is a 20-bit debounce counter.
- IDLE:
  - pressed_s=1 -> PRESS_WAIT with cnt=1.
- PRESS_WAIT:
  - pressed_s=0 -> IDLE, cnt cleared. This is a bounce; no outputs change.
  - pressed_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD. Same edge: press_pulse=1 for one cycle, held=1, press_count+=1, rcnt=0.
  - Otherwise cnt+=1.
- Press latency:
  - press_pulse rises exactly DEBOUNCE_CYCLES+2 clk edges after the first edge that samples key_n=0, provided key_n stays low throughout.
- HELD:
  - pressed_s=0 -> RELEASE_WAIT with cnt=1.
  - Otherwise, if REPEAT_EN=1, rcnt+=1. A repeat press_pulse fires when rcnt reaches REPEAT_DELAY; rcnt then reloads to REPEAT_DELAY-REPEAT_PERIOD so the next pulse is REPEAT_PERIOD later.
  - Repeat pulses do not change press_count.
- RELEASE_WAIT:
  - held stays 1 throughout.
  - pressed_s=1 -> HELD. No press_pulse, no count. rcnt keeps its value; the repeat schedule resumes.
  - pressed_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. Same edge: release_pulse=1 for one cycle, held=0.
  - Otherwise cnt+=1.
- Wrap: press_count 255 + accepted press -> 0.
- Counter width: counters never overflow for legal parameter values. rcnt is 25 bits.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 unless noted):
- Reset with key_n=1, then reset=1 for 20 cycles -> all outputs 0, no pulses.
- key_n low from edge 0, held 20 cycles, then high -> press_pulse high only at edge 6; held 1 from edge 6; press_count=1; release_pulse exactly one cycle, 6 edges after key_n rises; held drops the same cycle.
- Bounce: key_n low 3 cycles, high 1, low 3, high -> no press_pulse, press_count=0, held=0.
- Release glitch: while held, key_n high 2 cycles then low again -> no release_pulse, no second press_pulse, held stays 1, press_count unchanged.
- REPEAT_EN=1, hold 30 cycles past the accepted press -> repeat pulses at +10, +13, +16, +19, +22, +25, +28; press_count stays 1.
- Wrap and reset:
  - 256 clean presses -> press_count reads 0.
  - Separately, reset=0 while held=1 -> next edge: held=0 and press_count=0, with no release_pulse.
  - key_n kept low after reset deasserts -> press_pulse 6 edges later.
